aurora_link_recovery: RTL and testbench
=======================================

# aurora_link_recovery

Link supervisor for the single-lane Aurora 8b10b channel, in the USER_CLK domain. It watches channel/lane status and error strobes and issues reset requests back into the support reset logic. First it requests soft system resets, which drive the RESET input. After repeated failures it escalates to a GT reset request, which drives GT_RESET_IN through the existing INIT_CLK debouncer. It holds each request long enough to pass the 4-stage debouncers, and it treats the GT request as acknowledged when the synchronized GT reset returns.

## Interface
Parameters:
- UP_TIMEOUT, 2**20: cycles allowed in WAIT_UP for channel_up before a retry.
- RST_HOLD, 16: sys_reset_req pulse length in cycles; must be ≥ 4.
- MAX_RETRY, 4: system resets attempted before escalating to a GT reset.
- GT_HOLD_MAX, 4096: cycle cap on gt_reset_req while waiting for acknowledge.
- SOFT_ERR_LIMIT, 8: soft errors within one window that force a system reset.
- SOFT_WINDOW, 2**16: soft-error window length in cycles.

Ports:
- USER_CLK  in  1  clock.
- gt_rst_sync  in  1  reset. Asynchronous, active-high; also serves as the GT-reset acknowledge.
- enable  in  1  supervisor enable.
- channel_up  in  1  Aurora channel up.
- lane_up  in  1  Aurora lane up.
- hard_err  in  1  hard error, single-cycle strobe.
- soft_err  in  1  soft error, single-cycle strobe.
- sys_reset_req  out  1  drives RESET of the support reset logic.
- gt_reset_req  out  1  drives GT_RESET_IN.
- state  out  3  current FSM state.
- retry_cnt  out  4  system resets issued since last link-up.
- gt_ack_timeout  out  1  sticky: GT request hit GT_HOLD_MAX without acknowledge.

## Operation
- FSM states: DISABLED, WAIT_UP, UP, SYS_RST, GT_RST.
- All outputs are registered.
- **Reset** (gt_rst_sync high): state=DISABLED, sys_reset_req=0, gt_reset_req=0, retry_cnt=0, gt_ack_timeout=0, all counters 0.
- **DISABLED**: outputs low. Moves to WAIT_UP on the first cycle enable=1.
- **enable=0** in any state: move to DISABLED next cycle and drop both requests immediately. retry_cnt and gt_ack_timeout are kept.
- **WAIT_UP**: the timer counts from 0.
  - channel_up=1 and lane_up=1: go to UP and clear retry_cnt.
  - Timer reaches UP_TIMEOUT-1 with channel still down: fail.
- **UP**:
  - Fail on any of: channel_up falling, lane_up falling, a hard_err strobe, or the soft-error count reaching SOFT_ERR_LIMIT.
  - The soft-error window runs only in UP. It clears on window end and on entry to UP. The count saturates.
- **Fail rule**:
  - retry_cnt < MAX_RETRY: retry_cnt += 1, go to SYS_RST.
  - Otherwise: go to GT_RST.
- **SYS_RST**: sys_reset_req=1 for exactly RST_HOLD cycles, then WAIT_UP with the timer cleared. Status inputs are ignored during SYS_RST, since the core is being reset.
- **GT_RST**: gt_reset_req=1 until gt_rst_sync asserts. The asynchronous reset then returns the block to DISABLED, which is the acknowledge path. If GT_HOLD_MAX cycles elapse first: set gt_ack_timeout, drop the request, clear retry_cnt, go to WAIT_UP.
- **Simultaneous events**:
  - channel_up rising on the same cycle the timeout expires: UP wins.
  - hard_err, channel_up drop and soft limit on the same cycle: a single fail, one retry increment.
  - enable=0 coincident with any fail: DISABLED wins.

## Timing
- An event sampled at edge N changes state at N; the request output is high from edge N+1.
- sys_reset_req is high for RST_HOLD consecutive cycles, then low for at least 1 cycle before any new pulse. SYSTEM_RESET from the support logic follows 5 cycles later.
- gt_reset_req stays high ≥ 4 INIT_CLK periods plus sync latency, because it holds until acknowledged. GT_HOLD_MAX must exceed the worst-case round trip: 4 INIT_CLK + 1 INIT_CLK + 3 USER_CLK, with margin.
- The WAIT_UP timeout fires exactly UP_TIMEOUT cycles after WAIT_UP entry.
- Counter widths are $clog2 of their parameter plus 1. No wrap is possible, because each counter is cleared on state entry.

## Structure
- Package aurora_link_recovery_pkg holds:
  - the state encoding, as a 3-bit enum typedef;
  - the width helper constants.
- Sub-module aurora_link_recovery_soft_win is the windowed saturating soft-error counter. Ports: clk, rst, run, soft_err, limit_hit.

## Test plan
Parameters for all scenarios: UP_TIMEOUT=100, RST_HOLD=8, MAX_RETRY=2, GT_HOLD_MAX=64, SOFT_ERR_LIMIT=3, SOFT_WINDOW=50.
- **Clean bring-up**: enable=1, channel_up/lane_up rise at cycle 40 → state UP at cycle 41, no requests, retry_cnt=0.
- **Channel never up**: → sys_reset_req pulses of exactly 8 cycles start at cycles 101 and 209. retry_cnt reaches 2. At cycle 317 gt_reset_req rises. Assert gt_rst_sync 20 cycles later → all outputs 0, state DISABLED.
- **GT request never acknowledged**: gt_reset_req is high for exactly 64 cycles, then gt_ack_timeout=1, retry_cnt=0, state WAIT_UP.
- **Soft-error limit in UP**:
  - 3 soft_err strobes within 50 cycles → one 8-cycle sys_reset_req, retry_cnt=1.
  - 2 strobes in one window and 2 in the next → no reset.
- **Coincident failures**: hard_err coincident with channel_up drop → single SYS_RST, retry_cnt increments by 1.
- **enable dropped**: enable=0 at cycle 3 of a SYS_RST pulse → sys_reset_req low next cycle, state DISABLED, retry_cnt kept.

Source files
------------

// File: rtl/aurora_link_recovery_pkg.sv
`default_nettype none
// ============================================================================
// Module   : aurora_link_recovery_pkg
// Purpose  : State encoding and counter-width helpers shared by the Aurora
//            link supervisor, its interface and its soft-error window.
// Contents : state_e enum, ST_* legacy constants, STATE_W / RETRY_W,
//            cnt_w() and max_int() constant functions.
// Revision : 1.0 - initial release
// ============================================================================
package aurora_link_recovery_pkg;

  localparam int STATE_W = 3;
  localparam int RETRY_W = 4;

  typedef enum logic [STATE_W-1:0] {
    S_DISABLED = 3'd0,
    S_WAIT_UP  = 3'd1,
    S_UP       = 3'd2,
    S_SYS_RST  = 3'd3,
    S_GT_RST   = 3'd4
  } state_e;

  // Plain-vector aliases so the FSM register can stay a logic vector.
  localparam logic [STATE_W-1:0] ST_DISABLED = S_DISABLED;
  localparam logic [STATE_W-1:0] ST_WAIT_UP  = S_WAIT_UP;
  localparam logic [STATE_W-1:0] ST_UP       = S_UP;
  localparam logic [STATE_W-1:0] ST_SYS_RST  = S_SYS_RST;
  localparam logic [STATE_W-1:0] ST_GT_RST   = S_GT_RST;

  // One spare bit over $clog2 so a counter can hold the parameter value itself.
  function automatic int cnt_w(input int v);
    return $clog2(v) + 1;
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/aurora_link_recovery_if.sv
`default_nettype none
// ============================================================================
// Module   : aurora_link_recovery_if
// Purpose  : Status/request bundle between the Aurora core glue and the link
//            supervisor.
// Ports    : slave  - supervisor side: status in, requests/observability out
//            master - core/support side: drives status, sees requests
// Revision : 1.0 - initial release
// ============================================================================
interface aurora_link_recovery_if;
  import aurora_link_recovery_pkg::*;

  logic               enable;
  logic               channel_up;
  logic               lane_up;
  logic               hard_err;
  logic               soft_err;
  logic               sys_reset_req;
  logic               gt_reset_req;
  logic [STATE_W-1:0] state;
  logic [RETRY_W-1:0] retry_cnt;
  logic               gt_ack_timeout;

  modport master (
    output enable, channel_up, lane_up, hard_err, soft_err,
    input  sys_reset_req, gt_reset_req, state, retry_cnt, gt_ack_timeout
  );

  modport slave (
    input  enable, channel_up, lane_up, hard_err, soft_err,
    output sys_reset_req, gt_reset_req, state, retry_cnt, gt_ack_timeout
  );
endinterface
`default_nettype wire

// File: rtl/aurora_link_recovery_soft_win.sv
`default_nettype none
// ============================================================================
// Module   : aurora_link_recovery_soft_win
// Purpose  : Windowed, saturating soft-error counter. Counts soft_err strobes
//            while run is high; the window restarts every SOFT_WINDOW cycles
//            and whenever run is low.
// Ports    : clk, rst (async, active-high), run, soft_err in; limit_hit out
// Revision : 1.0 - initial release
// ============================================================================
module aurora_link_recovery_soft_win
  import aurora_link_recovery_pkg::*;
#(
  parameter int SOFT_ERR_LIMIT = 8,
  parameter int SOFT_WINDOW    = 2**16
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic soft_err,
  output logic limit_hit
);

  localparam int CW = cnt_w(SOFT_ERR_LIMIT);
  localparam int WW = cnt_w(SOFT_WINDOW);

  logic [CW-1:0] err_cnt;
  logic [WW-1:0] win_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_cnt <= '0;
      win_cnt <= '0;
    end else if (!run) begin
      err_cnt <= '0;
      win_cnt <= '0;
    end else if (win_cnt == WW'(SOFT_WINDOW - 1)) begin
      err_cnt <= '0;
      win_cnt <= '0;
    end else begin
      win_cnt <= win_cnt + 1'b1;
      if (soft_err && (err_cnt != CW'(SOFT_ERR_LIMIT)))
        err_cnt <= err_cnt + 1'b1;
    end
  end

  // Include the strobe being sampled so the limit is caught on the same edge,
  // even when that strobe lands in the last cycle of a window.
  assign limit_hit = run && ((err_cnt == CW'(SOFT_ERR_LIMIT)) ||
                             (soft_err && (err_cnt == CW'(SOFT_ERR_LIMIT - 1))));

endmodule
`default_nettype wire

// File: rtl/aurora_link_recovery.sv
`default_nettype none
// ============================================================================
// Module   : aurora_link_recovery
// Purpose  : Aurora 8b10b single-lane link supervisor. Retries with soft
//            system resets, escalates to a GT reset after MAX_RETRY failures,
//            and treats the returning synchronized GT reset as acknowledge.
// Ports    : USER_CLK      clock
//            gt_rst_sync   async active-high reset / GT-reset acknowledge
//            lnk (slave)   enable, channel_up, lane_up, hard_err, soft_err in;
//                          sys_reset_req, gt_reset_req, state, retry_cnt,
//                          gt_ack_timeout out (all registered)
// Revision : 1.0 - initial release
// ============================================================================
module aurora_link_recovery
  import aurora_link_recovery_pkg::*;
#(
  parameter int UP_TIMEOUT     = 2**20,
  parameter int RST_HOLD       = 16,
  parameter int MAX_RETRY      = 4,
  parameter int GT_HOLD_MAX    = 4096,
  parameter int SOFT_ERR_LIMIT = 8,
  parameter int SOFT_WINDOW    = 2**16
) (
  input  logic                 USER_CLK,
  input  logic                 gt_rst_sync,
  aurora_link_recovery_if.slave lnk
);

  // One timer serves WAIT_UP, SYS_RST and GT_RST; it is cleared on every
  // state entry, so sizing it for the largest limit is sufficient.
  localparam int TW = max_int(cnt_w(UP_TIMEOUT),
                              max_int(cnt_w(RST_HOLD), cnt_w(GT_HOLD_MAX)));

  logic [STATE_W-1:0] cur_state;
  logic [TW-1:0]      timer;
  logic [RETRY_W-1:0] retries;
  logic               sys_req;
  logic               gt_req;
  logic               ack_timeout;
  logic               limit_hit;
  logic               link_ok;
  logic               fail;

  aurora_link_recovery_soft_win #(
    .SOFT_ERR_LIMIT (SOFT_ERR_LIMIT),
    .SOFT_WINDOW    (SOFT_WINDOW)
  ) u_soft_win (
    .clk       (USER_CLK),
    .rst       (gt_rst_sync),
    .run       (cur_state == ST_UP),
    .soft_err  (lnk.soft_err),
    .limit_hit (limit_hit)
  );

  assign link_ok = lnk.channel_up && lnk.lane_up;

  // All fail causes collapse into one flag, so coincident causes count once.
  // Link-up wins over a simultaneous WAIT_UP timeout.
  always_comb begin
    fail = 1'b0;
    if (cur_state == ST_WAIT_UP)
      fail = !link_ok && (timer == TW'(UP_TIMEOUT - 1));
    else if (cur_state == ST_UP)
      fail = !link_ok || lnk.hard_err || limit_hit;
  end

  always_ff @(posedge USER_CLK or posedge gt_rst_sync) begin
    if (gt_rst_sync) begin
      cur_state   <= ST_DISABLED;
      timer       <= '0;
      retries     <= '0;
      sys_req     <= 1'b0;
      gt_req      <= 1'b0;
      ack_timeout <= 1'b0;
    end else begin
      // Requests trail the state by one edge; gating with enable drops them
      // on the same edge that the FSM falls back to DISABLED.
      sys_req <= lnk.enable && (cur_state == ST_SYS_RST);
      gt_req  <= lnk.enable && (cur_state == ST_GT_RST);

      if (!lnk.enable) begin
        cur_state <= ST_DISABLED;
        timer     <= '0;
      end else if (fail) begin
        timer <= '0;
        if (retries < RETRY_W'(MAX_RETRY)) begin
          retries   <= retries + 1'b1;
          cur_state <= ST_SYS_RST;
        end else begin
          cur_state <= ST_GT_RST;
        end
      end else begin
        case (cur_state)
          ST_DISABLED: begin
            cur_state <= ST_WAIT_UP;
            timer     <= '0;
          end
          ST_WAIT_UP: begin
            if (link_ok) begin
              cur_state <= ST_UP;
              retries   <= '0;
              timer     <= '0;
            end else begin
              timer <= timer + 1'b1;
            end
          end
          ST_UP: begin
            timer <= '0;
          end
          ST_SYS_RST: begin
            if (timer == TW'(RST_HOLD - 1)) begin
              cur_state <= ST_WAIT_UP;
              timer     <= '0;
            end else begin
              timer <= timer + 1'b1;
            end
          end
          ST_GT_RST: begin
            // Normal exit is the async reset; this is the no-acknowledge path.
            if (timer == TW'(GT_HOLD_MAX - 1)) begin
              ack_timeout <= 1'b1;
              retries     <= '0;
              cur_state   <= ST_WAIT_UP;
              timer       <= '0;
            end else begin
              timer <= timer + 1'b1;
            end
          end
          default: begin
            cur_state <= ST_DISABLED;
            timer     <= '0;
          end
        endcase
      end
    end
  end

  assign lnk.state          = cur_state;
  assign lnk.sys_reset_req  = sys_req;
  assign lnk.gt_reset_req   = gt_req;
  assign lnk.retry_cnt      = retries;
  assign lnk.gt_ack_timeout = ack_timeout;

endmodule
`default_nettype wire

// File: tb/tb_aurora_link_recovery.sv
`default_nettype none
// ============================================================================
// Module   : tb_aurora_link_recovery
// Purpose  : Directed self-checking bench for aurora_link_recovery with
//            UP_TIMEOUT=100, RST_HOLD=8, MAX_RETRY=2, GT_HOLD_MAX=64,
//            SOFT_ERR_LIMIT=3, SOFT_WINDOW=50. Edge 0 is the first clock
//            edge that samples enable=1; log[k] holds outputs after edge k.
// Revision : 1.0 - initial release
// ============================================================================
module tb_aurora_link_recovery;
  import aurora_link_recovery_pkg::*;

  logic USER_CLK = 1'b0;
  logic gt_rst_sync;
  always #5 USER_CLK = ~USER_CLK;

  aurora_link_recovery_if lnk();

  aurora_link_recovery #(
    .UP_TIMEOUT     (100),
    .RST_HOLD       (8),
    .MAX_RETRY      (2),
    .GT_HOLD_MAX    (64),
    .SOFT_ERR_LIMIT (3),
    .SOFT_WINDOW    (50)
  ) dut (
    .USER_CLK    (USER_CLK),
    .gt_rst_sync (gt_rst_sync),
    .lnk         (lnk)
  );

  int   checks   = 0;
  int   failures = 0;
  logic sys_log [0:511];
  logic gt_log  [0:511];

  task automatic step(input int n);
    repeat (n) begin
      @(posedge USER_CLK);
      #1;
    end
  endtask

  task automatic apply_reset();
    gt_rst_sync    = 1'b1;
    lnk.enable     = 1'b0;
    lnk.channel_up = 1'b0;
    lnk.lane_up    = 1'b0;
    lnk.hard_err   = 1'b0;
    lnk.soft_err   = 1'b0;
    step(3);
    gt_rst_sync = 1'b0;
    step(1);
  endtask

  task automatic run_log(input int n);
    for (int k = 0; k < 512; k++) begin
      sys_log[k] = 1'b0;
      gt_log[k]  = 1'b0;
    end
    for (int k = 0; k < n; k++) begin
      step(1);
      sys_log[k] = lnk.sys_reset_req;
      gt_log[k]  = lnk.gt_reset_req;
    end
  endtask

  function automatic int find_rise(input bit use_gt, input int from);
    for (int k = from; k < 511; k++) begin
      if (use_gt ? (!gt_log[k] && gt_log[k+1]) : (!sys_log[k] && sys_log[k+1]))
        return k + 1;
    end
    return -1;
  endfunction

  function automatic int pulse_len(input bit use_gt, input int start);
    int n = 0;
    if (start < 0) return 0;
    for (int k = start; k < 512; k++) begin
      if (use_gt ? !gt_log[k] : !sys_log[k]) return n;
      n++;
    end
    return n;
  endfunction

  task automatic test_reset();
    gt_rst_sync = 1'b1;
    lnk.enable  = 1'b1;
    lnk.channel_up = 1'b0; lnk.lane_up = 1'b0;
    lnk.hard_err = 1'b0;   lnk.soft_err = 1'b0;
    step(2);
    checks++; if (lnk.state !== ST_DISABLED) begin failures++; $display("FAIL reset_state got=%0d exp=%0d", lnk.state, ST_DISABLED); end
    checks++; if (lnk.sys_reset_req !== 1'b0) begin failures++; $display("FAIL reset_sys got=%b exp=0", lnk.sys_reset_req); end
    checks++; if (lnk.gt_reset_req !== 1'b0) begin failures++; $display("FAIL reset_gt got=%b exp=0", lnk.gt_reset_req); end
    checks++; if (lnk.retry_cnt !== 4'd0) begin failures++; $display("FAIL reset_retry got=%0d exp=0", lnk.retry_cnt); end
    checks++; if (lnk.gt_ack_timeout !== 1'b0) begin failures++; $display("FAIL reset_timeout got=%b exp=0", lnk.gt_ack_timeout); end
    lnk.enable  = 1'b0;
    gt_rst_sync = 1'b0;
    step(1);
  endtask

  task automatic test_bringup();
    logic saw_req = 1'b0;
    apply_reset();
    lnk.enable = 1'b1;
    for (int k = 0; k < 40; k++) begin
      step(1);
      saw_req = saw_req | lnk.sys_reset_req | lnk.gt_reset_req;
    end
    checks++; if (lnk.state !== ST_WAIT_UP) begin failures++; $display("FAIL bringup_wait got=%0d exp=%0d", lnk.state, ST_WAIT_UP); end
    lnk.channel_up = 1'b1; lnk.lane_up = 1'b1;
    step(1);
    checks++; if (lnk.state !== ST_UP) begin failures++; $display("FAIL bringup_up got=%0d exp=%0d", lnk.state, ST_UP); end
    checks++; if (saw_req !== 1'b0) begin failures++; $display("FAIL bringup_noreq got=%b exp=0", saw_req); end
    checks++; if (lnk.retry_cnt !== 4'd0) begin failures++; $display("FAIL bringup_retry got=%0d exp=0", lnk.retry_cnt); end
  endtask

  task automatic test_up_wins();
    apply_reset();
    lnk.enable = 1'b1;
    step(100);                       // now after edge 99
    lnk.channel_up = 1'b1; lnk.lane_up = 1'b1;
    step(1);                         // edge 100: timeout and link-up coincide
    checks++; if (lnk.state !== ST_UP) begin failures++; $display("FAIL upwins_state got=%0d exp=%0d", lnk.state, ST_UP); end
    step(1);
    checks++; if (lnk.sys_reset_req !== 1'b0) begin failures++; $display("FAIL upwins_sys got=%b exp=0", lnk.sys_reset_req); end
  endtask

  task automatic test_never_up();
    int r1, r2, g;
    apply_reset();
    lnk.enable = 1'b1;
    run_log(337);
    r1 = find_rise(1'b0, 0);
    r2 = find_rise(1'b0, r1 < 0 ? 0 : r1);
    g  = find_rise(1'b1, 0);
    checks++; if (r1 !== 101) begin failures++; $display("FAIL neverup_rise1 got=%0d exp=101", r1); end
    checks++; if (pulse_len(1'b0, r1) !== 8) begin failures++; $display("FAIL neverup_len1 got=%0d exp=8", pulse_len(1'b0, r1)); end
    checks++; if (r2 !== 209) begin failures++; $display("FAIL neverup_rise2 got=%0d exp=209", r2); end
    checks++; if (pulse_len(1'b0, r2) !== 8) begin failures++; $display("FAIL neverup_len2 got=%0d exp=8", pulse_len(1'b0, r2)); end
    checks++; if (g !== 317) begin failures++; $display("FAIL neverup_gtrise got=%0d exp=317", g); end
    checks++; if (lnk.retry_cnt !== 4'd2) begin failures++; $display("FAIL neverup_retry got=%0d exp=2", lnk.retry_cnt); end
    checks++; if (lnk.state !== ST_GT_RST) begin failures++; $display("FAIL neverup_gtstate got=%0d exp=%0d", lnk.state, ST_GT_RST); end
    // Acknowledge: synchronized GT reset returns 20 cycles after the request.
    gt_rst_sync = 1'b1;
    #1;
    checks++; if ({lnk.sys_reset_req, lnk.gt_reset_req, lnk.retry_cnt, lnk.gt_ack_timeout} !== 7'd0)
      begin failures++; $display("FAIL ack_outputs got=%b%b%0d%b exp=all zero", lnk.sys_reset_req, lnk.gt_reset_req, lnk.retry_cnt, lnk.gt_ack_timeout); end
    checks++; if (lnk.state !== ST_DISABLED) begin failures++; $display("FAIL ack_state got=%0d exp=%0d", lnk.state, ST_DISABLED); end
    step(1);
  endtask

  task automatic test_gt_timeout();
    int g;
    apply_reset();
    lnk.enable = 1'b1;
    run_log(400);
    g = find_rise(1'b1, 0);
    checks++; if (g !== 317) begin failures++; $display("FAIL gtto_rise got=%0d exp=317", g); end
    checks++; if (pulse_len(1'b1, g) !== 64) begin failures++; $display("FAIL gtto_len got=%0d exp=64", pulse_len(1'b1, g)); end
    checks++; if (lnk.gt_ack_timeout !== 1'b1) begin failures++; $display("FAIL gtto_flag got=%b exp=1", lnk.gt_ack_timeout); end
    checks++; if (lnk.retry_cnt !== 4'd0) begin failures++; $display("FAIL gtto_retry got=%0d exp=0", lnk.retry_cnt); end
    checks++; if (lnk.state !== ST_WAIT_UP) begin failures++; $display("FAIL gtto_state got=%0d exp=%0d", lnk.state, ST_WAIT_UP); end
    checks++; if (find_rise(1'b0, 300) !== -1) begin failures++; $display("FAIL gtto_nosys got=%0d exp=-1", find_rise(1'b0, 300)); end
    lnk.enable = 1'b0;
    step(1);
    checks++; if (lnk.state !== ST_DISABLED) begin failures++; $display("FAIL gtto_dis_state got=%0d exp=%0d", lnk.state, ST_DISABLED); end
    checks++; if (lnk.gt_ack_timeout !== 1'b1) begin failures++; $display("FAIL gtto_sticky got=%b exp=1", lnk.gt_ack_timeout); end
  endtask

  task automatic strobe_soft();
    lnk.soft_err = 1'b1;
    step(1);
    lnk.soft_err = 1'b0;
  endtask

  task automatic bring_up_link();
    apply_reset();
    lnk.enable = 1'b1;
    step(1);
    lnk.channel_up = 1'b1; lnk.lane_up = 1'b1;
    step(1);                         // UP entered on this edge (E)
  endtask

  task automatic test_soft_limit();
    int highs = 0;
    logic saw_req = 1'b0;
    bring_up_link();
    step(4); strobe_soft();          // E+5
    step(4); strobe_soft();          // E+10
    checks++; if (lnk.state !== ST_UP) begin failures++; $display("FAIL soft_two_state got=%0d exp=%0d", lnk.state, ST_UP); end
    step(4); strobe_soft();          // E+15: third in window
    checks++; if (lnk.state !== ST_SYS_RST) begin failures++; $display("FAIL soft_lim_state got=%0d exp=%0d", lnk.state, ST_SYS_RST); end
    checks++; if (lnk.retry_cnt !== 4'd1) begin failures++; $display("FAIL soft_lim_retry got=%0d exp=1", lnk.retry_cnt); end
    for (int k = 0; k < 30; k++) begin
      step(1);
      if (lnk.sys_reset_req) highs++;
    end
    checks++; if (highs !== 8) begin failures++; $display("FAIL soft_lim_pulse got=%0d exp=8", highs); end

    // Two strobes in each of two consecutive windows must not trip.
    bring_up_link();
    step(4);  strobe_soft();         // E+5
    step(4);  strobe_soft();         // E+10
    step(49); strobe_soft();         // E+60 (second window)
    step(4);  strobe_soft();         // E+65
    for (int k = 0; k < 20; k++) begin
      step(1);
      saw_req = saw_req | lnk.sys_reset_req;
    end
    checks++; if (saw_req !== 1'b0) begin failures++; $display("FAIL soft_win_noreq got=%b exp=0", saw_req); end
    checks++; if (lnk.state !== ST_UP) begin failures++; $display("FAIL soft_win_state got=%0d exp=%0d", lnk.state, ST_UP); end
  endtask

  task automatic test_coincident();
    int highs = 0;
    bring_up_link();
    step(3);
    lnk.hard_err = 1'b1; lnk.channel_up = 1'b0;
    step(1);
    lnk.hard_err = 1'b0;
    checks++; if (lnk.state !== ST_SYS_RST) begin failures++; $display("FAIL coin_state got=%0d exp=%0d", lnk.state, ST_SYS_RST); end
    checks++; if (lnk.retry_cnt !== 4'd1) begin failures++; $display("FAIL coin_retry got=%0d exp=1", lnk.retry_cnt); end
    for (int k = 0; k < 12; k++) begin
      step(1);
      if (lnk.sys_reset_req) highs++;
    end
    checks++; if (highs !== 8) begin failures++; $display("FAIL coin_pulse got=%0d exp=8", highs); end
    checks++; if (lnk.state !== ST_WAIT_UP) begin failures++; $display("FAIL coin_wait got=%0d exp=%0d", lnk.state, ST_WAIT_UP); end
    checks++; if (lnk.retry_cnt !== 4'd1) begin failures++; $display("FAIL coin_retry_after got=%0d exp=1", lnk.retry_cnt); end
  endtask

  task automatic test_enable_drop();
    bring_up_link();
    lnk.hard_err = 1'b1;
    step(1);
    lnk.hard_err = 1'b0;
    step(3);                         // third cycle of the pulse
    checks++; if (lnk.sys_reset_req !== 1'b1) begin failures++; $display("FAIL endrop_pulse got=%b exp=1", lnk.sys_reset_req); end
    lnk.enable = 1'b0;
    step(1);
    checks++; if (lnk.sys_reset_req !== 1'b0) begin failures++; $display("FAIL endrop_sys got=%b exp=0", lnk.sys_reset_req); end
    checks++; if (lnk.state !== ST_DISABLED) begin failures++; $display("FAIL endrop_state got=%0d exp=%0d", lnk.state, ST_DISABLED); end
    checks++; if (lnk.retry_cnt !== 4'd1) begin failures++; $display("FAIL endrop_retry got=%0d exp=1", lnk.retry_cnt); end
  endtask

  initial begin
    test_reset();
    test_bringup();
    test_up_wins();
    test_never_up();
    test_gt_timeout();
    test_soft_limit();
    test_coincident();
    test_enable_drop();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
